// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the async SRAM bus controller.
// Holds the access FSM encoding, the wait-state counter width and the
// byte-lane strobe helper used when byte masking is compiled in.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } state_t;

  // Widest byte-enable vector the lane helper accepts (512-bit data bus).
  localparam int BE_MAX = 64;

  // The counter must hold WAIT_CYCLES and stay at least one bit wide.
  function automatic int cnt_width(input int wait_cycles);
    return $clog2(wait_cycles + 2);
  endfunction

  // Maps byte enables onto the two active-low SRAM lanes {ub_n, lb_n}.
  // The lower half of the bytes feeds LB, the upper half feeds UB; a lane
  // is enabled when any byte in its half is enabled. A single-byte bus
  // drives both lanes from its only enable.
  function automatic logic [1:0] lane_n(input logic [BE_MAX-1:0] be, input int nbytes);
    logic ub;
    logic lb;
    ub = 1'b0;
    lb = 1'b0;
    for (int i = 0; i < BE_MAX; i++) begin
      if (i < nbytes) begin
        if ((nbytes == 1) || (i < nbytes / 2)) lb = lb | be[i];
        if ((nbytes == 1) || (i >= nbytes / 2)) ub = ub | be[i];
      end
    end
    return {~ub, ~lb};
  endfunction

endpackage

// File: rtl/sram_dq_io.sv
// Bidirectional SRAM data pad: tristate write driver plus read sample register.
// The driver follows drive_en combinationally; the sample lands one edge after capture.
// No handshake: the controller FSM decides when to drive and when to capture.
module sram_dq_io
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              capture,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] dq
);

  // Only the registered drive_en gates the pad, so the bus is released cleanly.
  assign dq = drive_en ? wdata : {DATA_W{1'bz}};

  // Read data register: keeps the last read result until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (capture) begin
      rdata <= dq;
    end
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// Async SRAM access controller: single-word read/write requests to SRAM strobes.
// Read: strobes held WAIT_CYCLES+1 cycles, response pulse on the following cycle;
// write adds one turnaround cycle. Requests are taken only in IDLE (req_ready), never queued.
// Optional byte masking on writes is compiled in with SRAM_BYTE_MASK_EN.
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [DATA_W-1:0]   SRAM_DQ,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              dq_oe;
  logic              capture;
  logic [1:0]        wr_lane_n;

  assign req_ready = (state == IDLE);

  // The read sample is taken on the edge that ends the strobe window.
  assign capture = (state == READ) && (cnt == '0);

`ifdef SRAM_BYTE_MASK_EN
  assign wr_lane_n = lane_n(BE_MAX'(req_be), BE_W);
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign wr_lane_n = 2'b00;
`endif

  // Access FSM: all strobes, address and pad enable are registered here.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      SRAM_ADDR <= '0;
      wdata_q   <= '0;
      dq_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            SRAM_ADDR <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_INIT;
            SRAM_CE_N <= 1'b0;
            if (req_we) begin
              state     <= WRITE;
              SRAM_WE_N <= 1'b0;
              SRAM_OE_N <= 1'b1;
              SRAM_UB_N <= wr_lane_n[1];
              SRAM_LB_N <= wr_lane_n[0];
              dq_oe     <= 1'b1;
            end else begin
              // Reads always fetch both lanes; OE_N only falls with the pad released.
              state     <= READ;
              SRAM_OE_N <= 1'b0;
              SRAM_WE_N <= 1'b1;
              SRAM_UB_N <= 1'b0;
              SRAM_LB_N <= 1'b0;
              dq_oe     <= 1'b0;
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            // WE_N rises first; data stays on the bus one more cycle for hold time.
            state     <= TURN;
            SRAM_WE_N <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TURN: begin
          state     <= IDLE;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          dq_oe     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sram_dq_io #(
    .DATA_W(DATA_W)
  ) u_dq (
    .clk      (Clk),
    .rst      (Reset),
    .drive_en (dq_oe),
    .wdata    (wdata_q),
    .capture  (capture),
    .rdata    (rsp_rdata),
    .dq       (SRAM_DQ)
  );

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: a WAIT_CYCLES=1 instance on a behavioural SRAM and a
// WAIT_CYCLES=0 instance on a fixed-content read-only SRAM. Read responses are
// checked by a scoreboard monitor; bus-safety invariants are checked every cycle.
module tb_sram_bus_ctrl;

  localparam int W = 1;

`ifdef SRAM_BYTE_MASK_EN
  localparam logic [15:0] BM_EXP   = 16'hAAFF;
  localparam logic [1:0]  BM_LANES = 2'b10;
`else
  localparam logic [15:0] BM_EXP   = 16'h12FF;
  localparam logic [1:0]  BM_LANES = 2'b00;
`endif

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   viol = 0;

  // W=1 instance signals
  logic        req_valid, req_we, req_ready, rsp_valid;
  logic [19:0] req_addr, sram_addr;
  logic [15:0] req_wdata, rsp_rdata;
  logic [1:0]  req_be;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  // W=0 instance signals
  logic        z_req_valid, z_req_we, z_req_ready, z_rsp_valid;
  logic [19:0] z_req_addr, z_addr;
  logic [15:0] z_req_wdata, z_rsp_rdata;
  logic [1:0]  z_req_be;
  wire  [15:0] z_dq;
  logic        z_ce_n, z_oe_n, z_we_n, z_ub_n, z_lb_n;

  logic [15:0] mem    [0:255];
  logic [15:0] shadow [0:255];
  exp_t        q  [$];
  exp_t        q0 [$];

  sram_bus_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(W)) dut (
    .Clk(clk), .Reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_bus_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .Reset(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
    .SRAM_ADDR(z_addr), .SRAM_DQ(z_dq),
    .SRAM_CE_N(z_ce_n), .SRAM_OE_N(z_oe_n), .SRAM_WE_N(z_we_n),
    .SRAM_UB_N(z_ub_n), .SRAM_LB_N(z_lb_n)
  );

  // Behavioural SRAM: drives DQ while selected and output-enabled.
  assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
  // Read-only SRAM for the zero-wait instance: addr 0 -> C0DE, addr 1 -> F00D.
  assign z_dq = (!z_ce_n && !z_oe_n) ? (z_addr[0] ? 16'hF00D : 16'hC0DE) : 16'hzzzz;

  // SRAM write port: latch enabled lanes mid-cycle while CE_N and WE_N are low.
  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Response monitor and per-cycle bus-safety watch.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        check("rsp_queue_nonempty", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        check("rsp_data", 32'(rsp_rdata), 32'(e.data));
        check("rsp_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (z_rsp_valid) begin
      if (q0.size() == 0) begin
        check("z_rsp_queue_nonempty", 32'(q0.size()), 32'd1);
      end else begin
        e = q0.pop_front();
        check("z_rsp_data", 32'(z_rsp_rdata), 32'(e.data));
        check("z_rsp_latency", 32'(cyc), 32'(e.due));
      end
    end
    if ((!oe_n && dut.dq_oe) || (!oe_n && !we_n) ||
        (!z_oe_n && dut0.dq_oe) || (!z_oe_n && !z_we_n)) begin
      viol <= viol + 1;
    end
  end

  // Issue one request on the W=1 instance; returns at the falling edge after acceptance.
  task automatic issue(input logic we, input logic [19:0] a, input logic [15:0] d,
                       input logic [1:0] be, input bit use_exp, input logic [15:0] exp_d);
    int   guard;
    exp_t e;
    guard = 0;
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      check("accept_timeout", 32'(guard), 32'd0);
      req_valid = 1'b0;
      return;
    end
    if (we) begin
`ifdef SRAM_BYTE_MASK_EN
      if (be[0]) shadow[a[7:0]][7:0]  = d[7:0];
      if (be[1]) shadow[a[7:0]][15:8] = d[15:8];
`else
      shadow[a[7:0]] = d;
`endif
    end else begin
      e.data = use_exp ? exp_d : shadow[a[7:0]];
      e.due  = cyc + W + 2;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 16'h0000;
      shadow[i] = 16'h0000;
    end

    // Reset state
    @(negedge clk);
    check("reset_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
    check("reset_addr", 32'(sram_addr), 32'h0);
    check("reset_rdata", 32'(rsp_rdata), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted in the first cycle of a write
    issue(1'b1, 20'h00040, 16'h1234, 2'b11, 1'b0, 16'h0);
    check("mw_we_low", 32'(we_n), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("mw_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
    check("mw_dq_released", 32'(dut.dq_oe), 32'h0);
    check("mw_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mw_ready_after", 32'(req_ready), 32'h1);

    // Write BEEF @0x12, then read it back
    issue(1'b1, 20'h00012, 16'hBEEF, 2'b11, 1'b0, 16'h0);
    check("wr_c1", 32'({we_n, oe_n, ce_n, req_ready}), 32'b0100);
    @(negedge clk);
    check("wr_c2", 32'({we_n, oe_n, ce_n, req_ready}), 32'b0100);
    check("wr_c2_dq", 32'(sram_dq), 32'hBEEF);
    @(negedge clk);
    check("wr_turn", 32'({we_n, oe_n, ce_n, req_ready, dut.dq_oe}), 32'b11001);
    @(negedge clk);
    check("wr_idle", 32'({ce_n, req_ready, dut.dq_oe}), 32'b110);
    issue(1'b0, 20'h00012, 16'h0, 2'b11, 1'b1, 16'hBEEF);
    check("rd_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'b00100);
    check("rd_addr", 32'(sram_addr), 32'h00012);
    repeat (4) @(negedge clk);

    // A request raised while a read is in flight must be ignored
    issue(1'b0, 20'h00012, 16'h0, 2'b11, 1'b1, 16'hBEEF);
    check("busy_ready", 32'(req_ready), 32'h0);
    req_we = 1'b1; req_addr = 20'h00012; req_wdata = 16'h5555; req_be = 2'b11; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("ign_no_write", 32'({we_n, ce_n}), 32'b11);
    issue(1'b0, 20'h00012, 16'h0, 2'b11, 1'b1, 16'hBEEF);
    repeat (4) @(negedge clk);

    // Partial write: 12FF with only the low byte enabled over AAAA
    issue(1'b1, 20'h00020, 16'hAAAA, 2'b11, 1'b0, 16'h0);
    issue(1'b1, 20'h00020, 16'h12FF, 2'b01, 1'b0, 16'h0);
    check("bm_lanes", 32'({ub_n, lb_n}), 32'(BM_LANES));
    issue(1'b0, 20'h00020, 16'h0, 2'b11, 1'b1, BM_EXP);
    repeat (4) @(negedge clk);

    // Zero-wait instance: back-to-back reads with req_valid held
    z_req_addr = 20'h0; z_req_valid = 1'b1;
    check("z_ready_idle", 32'(z_req_ready), 32'h1);
    n0 = cyc;
    q0.push_back('{data: 16'hC0DE, due: n0 + 2});
    @(negedge clk);
    check("z_busy", 32'(z_req_ready), 32'h0);
    z_req_addr = 20'h1;
    @(negedge clk);
    check("z_ready_again", 32'(z_req_ready), 32'h1);
    check("z_spacing", 32'(cyc - n0), 32'd2);
    q0.push_back('{data: 16'hF00D, due: cyc + 2});
    @(negedge clk);
    z_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic over a small address window
    for (int k = 0; k < 1000; k++) begin
      issue(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), 16'($urandom),
            2'($urandom_range(0, 3)), 1'b0, 16'h0);
    end
    repeat (6) @(negedge clk);

    check("queue_drained", 32'(q.size()), 32'd0);
    check("z_queue_drained", 32'(q0.size()), 32'd0);
    check("bus_contention", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
